// File: rtl/denumerate_pkg.sv
// denumerate_pkg: shared types and constants for the permutation-index decoder.
// Holds the factorial helper and table, the decoder state type, and the
// number of distinct permutations of CLB_K LUT inputs.

`ifndef CLB_N
`define CLB_N 8
`endif
`ifndef CLB_M
`define CLB_M 4
`endif
`ifndef CLB_K
`define CLB_K 4
`endif

package denumerate_pkg;

  localparam int PKG_K = `CLB_K;

  // n! for small n (elaboration-time use only)
  function automatic int fact(input int n);
    int acc;
    acc = 1;
    for (int i = 2; i <= n; i++) acc = acc * i;
    return acc;
  endfunction

  // Factorial table 0!..K! packed into one constant
  function automatic logic [PKG_K:0][31:0] fact_table();
    logic [PKG_K:0][31:0] t;
    for (int i = 0; i <= PKG_K; i++) t[i] = 32'(fact(i));
    return t;
  endfunction

  localparam logic [PKG_K:0][31:0] FACT       = fact_table();
  localparam int                   PERM_COUNT = fact(PKG_K);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/denumerate_nth_unused.sv
// nth_unused: combinational selector returning the d-th (from 0) element whose
// bit is clear in the used mask, plus a one-hot mask marking that element.
// When no such element exists both outputs are zero.

module nth_unused #(
  parameter int K  = 4,
  parameter int VW = 2
) (
  input  logic [K-1:0]  i_used,
  input  logic [VW-1:0] i_d,
  output logic [VW-1:0] o_val,
  output logic [K-1:0]  o_set
);

  logic [VW:0] w_cnt;
  logic        w_found;

  // Walk the mask from the smallest element, counting free slots until d is reached
  always_comb begin
    o_val   = '0;
    o_set   = '0;
    w_cnt   = '0;
    w_found = 1'b0;
    for (int i = 0; i < K; i++) begin
      if (!i_used[i]) begin
        if (!w_found && (w_cnt == {1'b0, i_d})) begin
          o_val    = VW'(i);
          o_set[i] = 1'b1;
          w_found  = 1'b1;
        end
        w_cnt = w_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/denumerate.sv
// denumerate: sequential decoder from an enumeration index back to the CLB_K
// slot LUT input permutation, one slot per cycle, valid/ready on both sides.
// Optional feature: define DENUMERATE_RANGECHK_EN to add the err output, which
// flags indices >= CLB_K! and forces the presented permutation to zero.

`ifndef CLB_N
`define CLB_N 8
`endif
`ifndef CLB_M
`define CLB_M 4
`endif
`ifndef CLB_K
`define CLB_K 4
`endif

module denumerate
  import denumerate_pkg::*;
#(
  parameter int  CLB_N     = `CLB_N,
  parameter int  CLB_M     = `CLB_M,
  parameter int  CLB_K     = `CLB_K,
  localparam int permWidth = $clog2(CLB_M + CLB_N),
  localparam int enumWidth = $clog2(fact(CLB_K) + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enm_vld,
  output logic                       enm_rdy,
  input  logic [enumWidth-1:0]       enm,
  output logic                       prm_vld,
  input  logic                       prm_rdy,
`ifdef DENUMERATE_RANGECHK_EN
  output logic                       err,
`endif
  output logic [permWidth*CLB_K-1:0] prm
);

  // Width of a slot value / position counter (values 0..CLB_K-1)
  localparam int VW = (CLB_K > 1) ? $clog2(CLB_K) : 1;

  state_t                     r_state;
  logic [enumWidth-1:0]       r_rem;
  logic [CLB_K-1:0]           r_used;
  logic [VW-1:0]              r_pos;
  logic [permWidth*CLB_K-1:0] r_prm;
  logic                       r_prm_vld;
`ifdef DENUMERATE_RANGECHK_EN
  logic                       r_err;
`endif

  // Constant comparison table: w_ge[p][m] = (m * p! <= r), w_prod[p][m] = m * p!
  logic                 w_ge   [CLB_K][CLB_K];
  logic [enumWidth-1:0] w_prod [CLB_K][CLB_K];

  genvar gi, gj;
  generate
    for (gi = 0; gi < CLB_K; gi++) begin : g_pos
      assign w_ge[gi][0]   = 1'b0;
      assign w_prod[gi][0] = '0;
      for (gj = 1; gj < CLB_K; gj++) begin : g_mul
        assign w_prod[gi][gj] = enumWidth'(gj * fact(gi));
        assign w_ge[gi][gj]   = (r_rem >= w_prod[gi][gj]);
      end
    end
  endgenerate

  logic [VW-1:0]        w_d;
  logic [enumWidth-1:0] w_sub;
  logic [VW-1:0]        w_val;
  logic [CLB_K-1:0]     w_set;
  logic                 w_slot_en;

  // Digit for the current position: largest m <= pos with m*pos! <= r (clamps d to pos)
  always_comb begin
    w_d   = '0;
    w_sub = '0;
    for (int m = 1; m < CLB_K; m++) begin
      if ((VW'(m) <= r_pos) && w_ge[r_pos][m]) begin
        w_d   = VW'(m);
        w_sub = w_prod[r_pos][m];
      end
    end
  end

  nth_unused #(
    .K  (CLB_K),
    .VW (VW)
  ) u_nth_unused (
    .i_used (r_used),
    .i_d    (w_d),
    .o_val  (w_val),
    .o_set  (w_set)
  );

`ifdef DENUMERATE_RANGECHK_EN
  assign w_slot_en = !r_err;
`else
  assign w_slot_en = 1'b1;
`endif

  // Control FSM plus remainder/used/position datapath and the output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_rem     <= '0;
      r_used    <= '0;
      r_pos     <= '0;
      r_prm     <= '0;
      r_prm_vld <= 1'b0;
`ifdef DENUMERATE_RANGECHK_EN
      r_err     <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (enm_vld) begin
            r_rem   <= enm;
            r_used  <= '0;
            r_pos   <= VW'(CLB_K - 1);
            r_prm   <= '0;
`ifdef DENUMERATE_RANGECHK_EN
            r_err   <= (enm >= enumWidth'(fact(CLB_K)));
`endif
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_rem  <= r_rem - w_sub;
          r_used <= r_used | w_set;
          if (w_slot_en)
            r_prm[permWidth*r_pos +: permWidth] <= permWidth'(w_val);
          if (r_pos == '0) begin
            r_state   <= ST_DONE;
            r_prm_vld <= 1'b1;
          end else begin
            r_pos <= r_pos - VW'(1);
          end
        end
        ST_DONE: begin
          if (prm_rdy) begin
            r_state   <= ST_IDLE;
            r_prm_vld <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_prm_vld <= 1'b0;
        end
      endcase
    end
  end

  assign enm_rdy = (r_state == ST_IDLE);
  assign prm_vld = r_prm_vld;
  assign prm     = r_prm;
`ifdef DENUMERATE_RANGECHK_EN
  assign err     = r_err;
`endif

endmodule

// File: tb/tb_denumerate.sv
// tb_denumerate: directed vector table plus hand-written multi-cycle sequences
// (round trip through a ranking model, backpressure, reset mid-decode and in DONE).
// Configured for CLB_K=4, CLB_N=8, CLB_M=4: 4-bit slots, 5-bit index.

module tb_denumerate;

  localparam int K  = 4;
  localparam int PW = 4;
  localparam int EW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          enm_vld;
  logic          enm_rdy;
  logic [EW-1:0] enm;
  logic          prm_vld;
  logic          prm_rdy;
  logic [15:0]   prm;
`ifdef DENUMERATE_RANGECHK_EN
  logic          dut_err;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  denumerate #(
    .CLB_N (8),
    .CLB_M (4),
    .CLB_K (K)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .enm_vld (enm_vld),
    .enm_rdy (enm_rdy),
    .enm     (enm),
    .prm_vld (prm_vld),
    .prm_rdy (prm_rdy),
`ifdef DENUMERATE_RANGECHK_EN
    .err     (dut_err),
`endif
    .prm     (prm)
  );

  task automatic chk(input string name, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Rank a permutation (slot 3 most significant); -1 if not a permutation
  task automatic rank_prm(input logic [15:0] v, output int idx);
    int   f [4] = '{1, 1, 2, 6};
    bit   [3:0] used;
    int   s, d;
    used = '0;
    idx  = 0;
    for (int p = K - 1; p >= 0; p--) begin
      s = int'(v[PW*p +: PW]);
      if (s >= K || used[s]) begin
        idx = -1;
        return;
      end
      d = 0;
      for (int j = 0; j < s; j++) if (!used[j]) d++;
      idx += d * f[p];
      used[s] = 1'b1;
    end
  endtask

  // Full transaction: accept index, wait for prm_vld (bounded), complete handshake
  task automatic decode(input logic [EW-1:0] e, output logic [15:0] got,
                        output int lat, output logic gerr);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!enm_rdy && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    enm     = e;
    enm_vld = 1'b1;
    @(posedge clk);
    #1 enm_vld = 1'b0;
    lat = 0;
    while (!prm_vld && lat < 50) begin
      @(posedge clk);
      #1 lat++;
    end
    got  = prm;
    gerr = 1'b0;
`ifdef DENUMERATE_RANGECHK_EN
    gerr = dut_err;
`endif
    prm_rdy = 1'b1;
    @(posedge clk);
    #1 prm_rdy = 1'b0;
  endtask

  typedef struct {
    logic [EW-1:0] enm;
    logic [15:0]   prm;
    logic          err;
  } vec_t;

  vec_t        vecs [8];
  logic [15:0] got;
  int          lat, idx, guard;
  logic        gerr;

  initial begin
    rst     = 1'b1;
    enm_vld = 1'b0;
    enm     = '0;
    prm_rdy = 1'b0;

    vecs[0] = '{5'd0,  16'h0123, 1'b0};
    vecs[1] = '{5'd1,  16'h0132, 1'b0};
    vecs[2] = '{5'd6,  16'h1023, 1'b0};
    vecs[3] = '{5'd9,  16'h1230, 1'b0};
    vecs[4] = '{5'd17, 16'h2310, 1'b0};
    vecs[5] = '{5'd23, 16'h3210, 1'b0};
`ifdef DENUMERATE_RANGECHK_EN
    vecs[6] = '{5'd24, 16'h0000, 1'b1};
    vecs[7] = '{5'd31, 16'h0000, 1'b1};
`else
    vecs[6] = '{5'd24, 16'h3210, 1'b0};
    vecs[7] = '{5'd31, 16'h3210, 1'b0};
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_prm_vld", prm_vld, 0);
    chk("reset_prm", prm, 0);
    chk("reset_enm_rdy", enm_rdy, 1);
`ifdef DENUMERATE_RANGECHK_EN
    chk("reset_err", dut_err, 0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors
    for (int i = 0; i < 8; i++) begin
      decode(vecs[i].enm, got, lat, gerr);
      $display("vec enm=%0d prm=%04h lat=%0d err=%0d", vecs[i].enm, got, lat, gerr);
      chk("vec_prm", got, vecs[i].prm);
      chk("vec_latency", lat, K);
`ifdef DENUMERATE_RANGECHK_EN
      chk("vec_err", gerr, vecs[i].err);
`endif
    end

    // Round trip through the ranking model
    for (int i = 0; i < 24; i++) begin
      decode(EW'(i), got, lat, gerr);
      rank_prm(got, idx);
      $display("roundtrip enm=%0d prm=%04h rank=%0d", i, got, idx);
      chk("roundtrip_rank", idx, i);
    end

    // Backpressure: hold prm_rdy low for 10 cycles in DONE
    @(negedge clk);
    enm = 5'd9; enm_vld = 1'b1;
    @(posedge clk);
    #1 enm_vld = 1'b0;
    chk("bp_rdy_in_run", enm_rdy, 0);
    guard = 0;
    while (!prm_vld && guard < 50) begin
      @(posedge clk);
      #1 guard++;
    end
    chk("bp_reach_done", prm_vld, 1);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      chk("bp_prm_stable", prm, 16'h1230);
      chk("bp_vld_held", prm_vld, 1);
      chk("bp_enm_rdy_low", enm_rdy, 0);
    end
    prm_rdy = 1'b1;
    @(posedge clk);
    #1 prm_rdy = 1'b0;
    chk("bp_release_vld", prm_vld, 0);
    chk("bp_release_idle", enm_rdy, 1);
    $display("backpressure enm=9 prm=%04h held 10 cycles", 16'h1230);

    // Asynchronous reset at edge 2 of a decode
    @(negedge clk);
    enm = 5'd23; enm_vld = 1'b1;
    @(posedge clk);
    #1 enm_vld = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 chk("midrun_partial_prm", prm, 16'h3200);
    rst = 1'b1;
    #1;
    chk("midrun_rst_vld", prm_vld, 0);
    chk("midrun_rst_prm", prm, 0);
    chk("midrun_rst_rdy", enm_rdy, 1);
    @(negedge clk);
    rst = 1'b0;
    decode(5'd23, got, lat, gerr);
    $display("after reset enm=23 prm=%04h lat=%0d", got, lat);
    chk("post_rst_prm", got, 16'h3210);
    chk("post_rst_latency", lat, K);

    // Reset while DONE is stalled
    @(negedge clk);
    enm = 5'd17; enm_vld = 1'b1;
    @(posedge clk);
    #1 enm_vld = 1'b0;
    guard = 0;
    while (!prm_vld && guard < 50) begin
      @(posedge clk);
      #1 guard++;
    end
    repeat (2) @(posedge clk);
    #1 chk("done_stall_prm", prm, 16'h2310);
    rst = 1'b1;
    #1;
    chk("done_rst_vld", prm_vld, 0);
    chk("done_rst_prm", prm, 0);
    chk("done_rst_rdy", enm_rdy, 1);
    @(negedge clk);
    rst = 1'b0;
    $display("reset in DONE enm=17 discarded");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
